// File: rtl/ram_rd_chk_if.sv
// rtl/ram_rd_chk_if.sv - RAM read port bundle between the checker and the RAM
//   ram_en    : port enable (checker -> RAM)
//   ram_we    : write enable, always 0 from the checker (checker -> RAM)
//   ram_addr  : read address (checker -> RAM)
//   ram_rdata : read data (RAM -> checker)
interface ram_rd_chk_if #(
    parameter int DEPTH_LOG2 = 5,
    parameter int DATA_W     = 8
);
    logic                  ram_en;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [DATA_W-1:0]     ram_rdata;

    modport master (
        output ram_en,
        output ram_we,
        output ram_addr,
        input  ram_rdata
    );

    modport slave (
        input  ram_en,
        input  ram_we,
        input  ram_addr,
        output ram_rdata
    );
endinterface

// File: rtl/ram_rd_chk.sv
// rtl/ram_rd_chk.sv - sweeps every RAM word once and counts words where mem[a] != a
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   start              : one-cycle request for a check pass (ignored unless IDLE)
//   ram                : RAM read port (master side)
//   busy               : pass in progress (READ and DRAIN)
//   done               : one-cycle pulse at the end of a pass
//   pass               : last completed pass had no mismatches
//   err_cnt            : mismatch count of the current / last pass
//   first_err_addr     : address of the first mismatch of the last pass, else 0
module ram_rd_chk #(
    parameter int RD_LAT     = 1,
    parameter int DEPTH_LOG2 = 5,
    parameter int DATA_W     = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    ram_rd_chk_if.master          ram,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [DEPTH_LOG2:0]   err_cnt,
    output logic [DEPTH_LOG2-1:0] first_err_addr
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [DEPTH_LOG2-1:0] LAST_ADDR  = '1;
    localparam logic [2:0]            DRAIN_LAST = 3'(RD_LAT);

    state_t state;
    logic [2:0] drain_cnt;

    // Valid/address shadow of each issued read; stage RD_LAT-1 lines up
    // with the cycle the RAM returns that address's data.
    logic [RD_LAT-1:0]                 pipe_vld;
    logic [RD_LAT-1:0][DEPTH_LOG2-1:0] pipe_addr;

    logic                  cmp_vld;
    logic [DEPTH_LOG2-1:0] cmp_addr;
    logic                  mismatch;

    assign cmp_vld  = pipe_vld[RD_LAT-1];
    assign cmp_addr = pipe_addr[RD_LAT-1];
    // Only a valid slot may count; rdata in any other cycle is don't-care.
    assign mismatch = cmp_vld && (ram.ram_rdata != DATA_W'(cmp_addr));

    assign ram.ram_we = 1'b0;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pipe_vld  <= '0;
            pipe_addr <= '0;
        end else begin
            pipe_vld[0]  <= (state == READ);
            pipe_addr[0] <= ram.ram_addr;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_vld[k]  <= pipe_vld[k-1];
                pipe_addr[k] <= pipe_addr[k-1];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= IDLE;
            drain_cnt      <= '0;
            ram.ram_en     <= 1'b0;
            ram.ram_addr   <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= READ;
                        ram.ram_addr   <= '0;
                        ram.ram_en     <= 1'b1;
                        busy           <= 1'b1;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                    end
                end
                READ: begin
                    if (ram.ram_addr == LAST_ADDR) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        ram.ram_addr <= ram.ram_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    // The final compare lands one cycle before the last DRAIN
                    // cycle, so err_cnt is already settled here.
                    if (drain_cnt == DRAIN_LAST) begin
                        state      <= DONE;
                        ram.ram_en <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        pass       <= (err_cnt == '0);
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // Compares only occur during READ/DRAIN, never alongside the
            // clear on start, so these writes never collide with it.
            if (mismatch) begin
                err_cnt <= err_cnt + 1'b1;
                if (err_cnt == '0) begin
                    first_err_addr <= cmp_addr;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_rd_chk.sv
// tb/tb_ram_rd_chk.sv - scoreboard bench for ram_rd_chk at RD_LAT 1 and 3
module tb_ram_rd_chk;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int N  = 32;

    typedef struct {
        int lat;
        int err;
        int first;
        int pass;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic start1 = 1'b0;
    logic start3 = 1'b0;

    logic          busy1, done1, pass1, busy3, done3, pass3;
    logic [AW:0]   err1, err3;
    logic [AW-1:0] fea1, fea3;

    logic [DW-1:0] mem1 [N];
    logic [DW-1:0] mem3 [N];
    logic [DW-1:0] rp1;
    logic [DW-1:0] rp3 [3];

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb [$];
    int   last_pass1 = 0;
    int   last_pass3 = 0;

    logic          o_done, o_busy, o_pass, o_en, o_we;
    logic [AW:0]   o_err;
    logic [AW-1:0] o_fea, o_addr;

    ram_rd_chk_if #(.DEPTH_LOG2(AW), .DATA_W(DW)) bus1 ();
    ram_rd_chk_if #(.DEPTH_LOG2(AW), .DATA_W(DW)) bus3 ();

    ram_rd_chk #(.RD_LAT(1), .DEPTH_LOG2(AW), .DATA_W(DW)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start1), .ram(bus1.master),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_err_addr(fea1)
    );

    ram_rd_chk #(.RD_LAT(3), .DEPTH_LOG2(AW), .DATA_W(DW)) dut3 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start3), .ram(bus3.master),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .first_err_addr(fea3)
    );

    always #5 sys_clk = ~sys_clk;

    // RAM models: read latency 1 and 3; garbage whenever the port is disabled
    always @(posedge sys_clk) begin
        rp1    <= bus1.ram_en ? mem1[bus1.ram_addr] : DW'($urandom);
        rp3[0] <= bus3.ram_en ? mem3[bus3.ram_addr] : DW'($urandom);
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign bus1.ram_rdata = rp1;
    assign bus3.ram_rdata = rp3[2];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_start(input int lat, input logic v);
        if (lat == 1) start1 = v;
        else start3 = v;
    endtask

    task automatic sample(input int lat);
        o_done = (lat == 1) ? done1 : done3;
        o_busy = (lat == 1) ? busy1 : busy3;
        o_pass = (lat == 1) ? pass1 : pass3;
        o_err  = (lat == 1) ? err1  : err3;
        o_fea  = (lat == 1) ? fea1  : fea3;
        o_en   = (lat == 1) ? bus1.ram_en   : bus3.ram_en;
        o_we   = (lat == 1) ? bus1.ram_we   : bus3.ram_we;
        o_addr = (lat == 1) ? bus1.ram_addr : bus3.ram_addr;
    endtask

    function automatic exp_t model(input int lat);
        exp_t e;
        logic [DW-1:0] w;
        e.lat = lat; e.err = 0; e.first = 0;
        for (int a = 0; a < N; a++) begin
            w = (lat == 1) ? mem1[a] : mem3[a];
            if (w != DW'(a)) begin
                if (e.err == 0) e.first = a;
                e.err++;
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic fill(input int lat, input int inv);
        for (int a = 0; a < N; a++) begin
            if (lat == 1) mem1[a] = inv ? ~DW'(a) : DW'(a);
            else          mem3[a] = inv ? ~DW'(a) : DW'(a);
        end
    endtask

    task automatic run_pass(input int lat, input bit extra, input string tag);
        exp_t e;
        int   k;
        int   n;
        bit   addr_ok;
        bit   seen;
        sb.push_back(model(lat));
        set_start(lat, 1'b1);
        @(negedge sys_clk);
        set_start(lat, 1'b0);
        sample(lat);
        check({tag, "_clr_err"}, o_err, 0);
        check({tag, "_clr_first"}, o_fea, 0);
        check({tag, "_pass_hold"}, o_pass, (lat == 1) ? last_pass1 : last_pass3);
        check({tag, "_busy"}, o_busy, 1);
        addr_ok = 1'b1; seen = 1'b0; k = 0;
        while (k < 100) begin
            if (k < N) begin
                if (o_addr != AW'(k) || !o_en) addr_ok = 1'b0;
            end else if (o_busy) begin
                if (o_addr != AW'(N - 1) || !o_en) addr_ok = 1'b0;
            end
            set_start(lat, extra && (k == 9 || k == N));
            @(negedge sys_clk);
            k++;
            sample(lat);
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        set_start(lat, 1'b0);
        check({tag, "_done_seen"}, seen, 1);
        e = (sb.size() > 0) ? sb.pop_front() : '{lat: lat, err: -1, first: -1, pass: -1};
        if (seen) begin
            check({tag, "_latency"}, k, N + lat + 1);
            check({tag, "_err_cnt"}, o_err, e.err);
            check({tag, "_first_err"}, o_fea, e.first);
            check({tag, "_pass"}, o_pass, e.pass);
            check({tag, "_done_busy"}, o_busy, 0);
            check({tag, "_done_en"}, o_en, 0);
            check({tag, "_addr_seq"}, addr_ok, 1);
            if (lat == 1) last_pass1 = e.pass;
            else last_pass3 = e.pass;
        end
        // a start during DONE must be dropped
        if (extra) set_start(lat, 1'b1);
        @(negedge sys_clk);
        set_start(lat, 1'b0);
        sample(lat);
        check({tag, "_done_pulse"}, o_done, 0);
        n = 0;
        repeat (8) begin
            @(negedge sys_clk);
            sample(lat);
            if (o_busy || o_done) n++;
        end
        check({tag, "_idle_hold"}, n, 0);
        check({tag, "_hold_err"}, o_err, e.err);
    endtask

    initial begin
        int n;
        fill(1, 0);
        fill(3, 0);
        repeat (3) @(negedge sys_clk);
        sample(1);
        check("rst_en", o_en, 0);
        check("rst_we", o_we, 0);
        check("rst_addr", o_addr, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_pass", o_pass, 0);
        check("rst_err", o_err, 0);
        check("rst_first", o_fea, 0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        run_pass(1, 1'b0, "clean1");
        mem1[5] = 8'hFF; mem1[20] = 8'h00;
        run_pass(1, 1'b0, "two_err");
        fill(1, 1);
        run_pass(1, 1'b0, "all_err");
        run_pass(3, 1'b0, "clean3");
        mem3[31] = 8'h00;
        run_pass(3, 1'b0, "last3");
        fill(1, 0);
        run_pass(1, 1'b1, "restart");

        // reset in the middle of a pass that has already seen a mismatch
        mem1[3] = 8'h55;
        start1 = 1'b1;
        @(negedge sys_clk);
        start1 = 1'b0;
        repeat (14) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        sample(1);
        check("mid_rst_en", o_en, 0);
        check("mid_rst_addr", o_addr, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_pass", o_pass, 0);
        check("mid_rst_err", o_err, 0);
        check("mid_rst_first", o_fea, 0);
        n = 0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (50) begin
            @(negedge sys_clk);
            sample(1);
            if (o_done || o_busy) n++;
        end
        check("mid_rst_no_done", n, 0);
        last_pass1 = 0;
        mem1[3] = 8'h03;
        run_pass(1, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
